wb_rr_arbiter: RTL

Parametrised N-master to one-slave Wishbone round-robin arbiter. It generalises the fixed two-requester SoC bus arbiter to any master count. A grant is held for the whole bus cycle (cyc), so burst and locked accesses work, and an optional watchdog recovers a hung slave. It sits between the CPU instruction/data cache buses plus DMA masters and the main SoC interconnect.

---
 rtl/wb_rr_arbiter_pkg.sv | 54 +++++
 rtl/wb_rr_arbiter_if.sv | 70 +++++++
 rtl/wb_rr_arbiter_rr_pick.sv | 46 ++++
 rtl/wb_rr_arbiter.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/wb_rr_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// wb_arb_pkg
// Shared types, default parameter values and helper functions for the
// Wishbone round-robin arbiter and its rotating-priority encoder.
//
// Contents:
//   arb_state_e     - arbiter FSM state encoding (IDLE, BUSY, DRAIN)
//   clog2_w()       - ceiling log2 with a minimum result of 1 bit
//   onehot_to_idx() - binary index of the set bit in a one-hot vector
//   DEF_*           - default parameter values
//
// The DRAIN state is only reachable when ARB_TIMEOUT_EN is defined.
// -----------------------------------------------------------------------------
package wb_arb_pkg;

    localparam int DEF_N_MASTERS   = 4;
    localparam int DEF_ADDR_W      = 30;
    localparam int DEF_DATA_W      = 32;
    localparam int DEF_TIMEOUT_CYC = 1024;

    // Largest master count the one-hot helper below supports.
    localparam int MAX_MASTERS     = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2
    } arb_state_e;

    // Ceiling log2, never smaller than 1 so it can size a vector directly.
    function automatic int clog2_w(input int value);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((32'sd1 <<< w) < value) begin
                w = w + 1;
            end
        end
        return w;
    endfunction

    // Binary index of a one-hot vector; an all-zero vector yields 0.
    function automatic logic [3:0] onehot_to_idx(input logic [MAX_MASTERS-1:0] oh);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 0; i < MAX_MASTERS; i++) begin
            if (oh[i]) begin
                idx = idx | 4'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/wb_rr_arbiter_if.sv
// -----------------------------------------------------------------------------
// wb_rr_arbiter_if
// Bus bundle between N Wishbone masters, the round-robin arbiter and the one
// shared slave. Per-master signals are flattened vectors; master i occupies
// slice i of each vector.
//
// Signals:
//   m_cyc/m_stb/m_we [N]      master cycle, strobe, write enable
//   m_adr   [N*ADDR_W]        master word addresses
//   m_dat_w [N*DATA_W]        master write data
//   m_sel   [N*SEL_W]         master byte selects
//   m_dat_r [DATA_W]          read data broadcast to all masters
//   m_ack/m_err [N]           per-master termination
//   s_cyc/s_stb/s_we          slave controls
//   s_adr/s_dat_w/s_sel       slave address, write data, byte selects
//   s_dat_r/s_ack/s_err       slave responses
//   grant [N]                 one-hot current owner (0 when idle)
//
// Modports:
//   slave  - the arbiter's view (a slave to the masters, driving the slave bus)
//   master - the surrounding system's view (masters plus the shared slave)
// -----------------------------------------------------------------------------
interface wb_rr_arbiter_if
    import wb_arb_pkg::*;
#(
    parameter int N_MASTERS = DEF_N_MASTERS,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W
);
    localparam int SEL_W = DATA_W / 8;

    logic [N_MASTERS-1:0]        m_cyc;
    logic [N_MASTERS-1:0]        m_stb;
    logic [N_MASTERS-1:0]        m_we;
    logic [N_MASTERS*ADDR_W-1:0] m_adr;
    logic [N_MASTERS*DATA_W-1:0] m_dat_w;
    logic [N_MASTERS*SEL_W-1:0]  m_sel;
    logic [DATA_W-1:0]           m_dat_r;
    logic [N_MASTERS-1:0]        m_ack;
    logic [N_MASTERS-1:0]        m_err;

    logic                        s_cyc;
    logic                        s_stb;
    logic                        s_we;
    logic [ADDR_W-1:0]           s_adr;
    logic [DATA_W-1:0]           s_dat_w;
    logic [SEL_W-1:0]            s_sel;
    logic [DATA_W-1:0]           s_dat_r;
    logic                        s_ack;
    logic                        s_err;

    logic [N_MASTERS-1:0]        grant;

    modport slave (
        input  m_cyc, m_stb, m_we, m_adr, m_dat_w, m_sel,
        input  s_dat_r, s_ack, s_err,
        output m_dat_r, m_ack, m_err,
        output s_cyc, s_stb, s_we, s_adr, s_dat_w, s_sel,
        output grant
    );

    modport master (
        output m_cyc, m_stb, m_we, m_adr, m_dat_w, m_sel,
        output s_dat_r, s_ack, s_err,
        input  m_dat_r, m_ack, m_err,
        input  s_cyc, s_stb, s_we, s_adr, s_dat_w, s_sel,
        input  grant
    );

endinterface

// File: rtl/wb_rr_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Purely combinational rotating-priority encoder. The search starts at
// last+1, wraps modulo N and returns the first requester found as a one-hot
// vector. Output is all-zero when valid is low or nobody requests.
//
// Ports:
//   req   [N]      request vector
//   last  [IDX_W]  index of the previous winner (lowest priority this round)
//   valid          enable; win is forced to zero when low
//   win   [N]      one-hot winner
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    input  logic             valid,
    output logic [N-1:0]     win
);

    logic [IDX_W-1:0] idx_s;
    logic             found_s;

    // Walk the N candidates in rotated order and keep only the first hit.
    always_comb begin
        win     = '0;
        found_s = 1'b0;
        idx_s   = '0;
        if (valid) begin
            for (int k = 1; k <= N; k++) begin
                idx_s = IDX_W'((int'(last) + k) % N);
                if (!found_s && req[idx_s]) begin
                    win[idx_s] = 1'b1;
                    found_s    = 1'b1;
                end else begin
                    found_s = found_s;
                end
            end
        end else begin
            win = '0;
        end
    end

endmodule

// File: rtl/wb_rr_arbiter.sv
// -----------------------------------------------------------------------------
// wb_rr_arbiter
// N-master to one-slave Wishbone round-robin arbiter. A grant is held for the
// whole bus cycle (while the owner keeps cyc high), so bursts and locked
// sequences are never split. One dead IDLE cycle separates consecutive owners.
// The ack/err return path and the address/data forward path are combinational
// once a grant is registered.
//
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset; outputs drop to zero immediately
//   bus    wb_rr_arbiter_if.slave - master vectors, slave bus, grant
//
// Optional feature (macro ARB_TIMEOUT_EN):
//   A watchdog counts stalled strobe cycles. On reaching TIMEOUT_CYC-1 it
//   pulses m_err to the owner for one cycle, drops s_cyc/s_stb and enters
//   DRAIN, where the slave is isolated until the owner lowers cyc.
//   Without the macro there is no counter and no DRAIN state.
// -----------------------------------------------------------------------------
module wb_rr_arbiter
    import wb_arb_pkg::*;
#(
    parameter int N_MASTERS   = DEF_N_MASTERS,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input logic              clk,
    input logic              rst_n,
    wb_rr_arbiter_if.slave   bus
);

    localparam int SEL_W = DATA_W / 8;
    localparam int IDX_W = clog2_w(N_MASTERS);

    arb_state_e             state_r;
    arb_state_e             state_nxt_s;
    logic [N_MASTERS-1:0]   grant_r;
    logic [N_MASTERS-1:0]   grant_nxt_s;
    logic [IDX_W-1:0]       gidx_r;
    logic [IDX_W-1:0]       gidx_nxt_s;
    logic [IDX_W-1:0]       last_r;
    logic [IDX_W-1:0]       last_nxt_s;
    logic [N_MASTERS-1:0]   win_s;
    logic                   cyc_g_s;
    logic                   stb_g_s;
    logic                   timeout_s;

    // Owner's cyc/stb, selected by the registered grant index.
    assign cyc_g_s = bus.m_cyc[gidx_r];
    assign stb_g_s = bus.m_stb[gidx_r];

    // Read data is a plain broadcast; only the owner sees an ack.
    assign bus.m_dat_r = bus.s_dat_r;
    assign bus.grant   = grant_r;

    rr_pick #(
        .N     (N_MASTERS),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req   (bus.m_cyc),
        .last  (last_r),
        .valid (state_r == IDLE),
        .win   (win_s)
    );

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = clog2_w(TIMEOUT_CYC);

    logic [CNT_W-1:0] wd_cnt_r;
    logic             stall_s;

    // A stall is a strobe from the owner that the slave has not terminated.
    assign stall_s   = (state_r == BUSY) && stb_g_s && !bus.s_ack && !bus.s_err;
    assign timeout_s = stall_s && (wd_cnt_r == CNT_W'(TIMEOUT_CYC - 1));

    // Watchdog counter: counts consecutive stalled cycles, clears otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt_r <= '0;
        end else if (stall_s && !timeout_s) begin
            wd_cnt_r <= wd_cnt_r + CNT_W'(1);
        end else begin
            wd_cnt_r <= '0;
        end
    end
`else
    logic unused_timeout_cfg_s;

    assign timeout_s            = 1'b0;
    assign unused_timeout_cfg_s = (TIMEOUT_CYC > 0);
`endif

    // FSM, grant and last-owner registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            grant_r <= '0;
            gidx_r  <= '0;
            last_r  <= IDX_W'(N_MASTERS - 1);
        end else begin
            state_r <= state_nxt_s;
            grant_r <= grant_nxt_s;
            gidx_r  <= gidx_nxt_s;
            last_r  <= last_nxt_s;
        end
    end

    // Next-state logic: arbitrate in IDLE, hold the grant until the owner's
    // cyc falls, then remember the owner so it has lowest priority next time.
    always_comb begin
        state_nxt_s = state_r;
        grant_nxt_s = grant_r;
        gidx_nxt_s  = gidx_r;
        last_nxt_s  = last_r;
        case (state_r)
            IDLE: begin
                if (|bus.m_cyc) begin
                    state_nxt_s = BUSY;
                    grant_nxt_s = win_s;
                    gidx_nxt_s  = IDX_W'(onehot_to_idx(MAX_MASTERS'(win_s)));
                end else begin
                    grant_nxt_s = '0;
                end
            end
            BUSY: begin
`ifdef ARB_TIMEOUT_EN
                if (timeout_s) begin
                    state_nxt_s = DRAIN;
                end else if (!cyc_g_s) begin
                    state_nxt_s = IDLE;
                    grant_nxt_s = '0;
                    last_nxt_s  = gidx_r;
                end else begin
                    state_nxt_s = BUSY;
                end
`else
                if (!cyc_g_s) begin
                    state_nxt_s = IDLE;
                    grant_nxt_s = '0;
                    last_nxt_s  = gidx_r;
                end else begin
                    state_nxt_s = BUSY;
                end
`endif
            end
`ifdef ARB_TIMEOUT_EN
            DRAIN: begin
                // Wait for the owner to abandon its cycle; the slave stays cut off.
                if (!cyc_g_s) begin
                    state_nxt_s = IDLE;
                    grant_nxt_s = '0;
                    last_nxt_s  = gidx_r;
                end else begin
                    state_nxt_s = DRAIN;
                end
            end
`endif
            default: begin
                state_nxt_s = IDLE;
                grant_nxt_s = '0;
            end
        endcase
    end

    // Bus muxing: only BUSY connects the owner to the slave. Everything else
    // (IDLE, DRAIN, reset) presents an all-zero slave bus and no terminations.
    always_comb begin
        bus.s_cyc   = 1'b0;
        bus.s_stb   = 1'b0;
        bus.s_we    = 1'b0;
        bus.s_adr   = '0;
        bus.s_dat_w = '0;
        bus.s_sel   = '0;
        bus.m_ack   = '0;
        bus.m_err   = '0;
        if (state_r == BUSY) begin
            bus.s_cyc         = cyc_g_s & ~timeout_s;
            bus.s_stb         = stb_g_s & ~timeout_s;
            bus.s_we          = bus.m_we[gidx_r];
            bus.s_adr         = bus.m_adr[int'(gidx_r) * ADDR_W +: ADDR_W];
            bus.s_dat_w       = bus.m_dat_w[int'(gidx_r) * DATA_W +: DATA_W];
            bus.s_sel         = bus.m_sel[int'(gidx_r) * SEL_W +: SEL_W];
            bus.m_ack[gidx_r] = bus.s_ack;
            bus.m_err[gidx_r] = bus.s_err | timeout_s;
        end else begin
            bus.s_cyc = 1'b0;
        end
    end

endmodule
